// File: rtl/relogio_pkg.sv
// Shared definitions for the relogio clock stages: field widths, default
// moduli and the time-setting FSM state encoding.
package relogio_pkg;

  localparam int MIN_W        = 6;
  localparam int HOUR_W       = 5;
  localparam int DEF_MIN_MOD  = 60;
  localparam int DEF_HOUR_MOD = 24;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } set_state_t;

endpackage

// File: rtl/relogio_rise_detect.sv
// Rising-edge detector for a level that is already synchronous to clk.
// The previous-sample register resets to 1, so a level that is already high
// when reset is released is not treated as a new edge.
module relogio_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  // Remember the level from the previous clock for edge comparison.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b1;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/relogio_min_hora.sv
// Minutes/hours stage of the clock. Counts one minute per rising edge of the
// seconds-stage wrap strobe, lets the user set hours then minutes with two
// buttons, and pulses day_tick when the hours wrap back to zero.
module relogio_min_hora
  import relogio_pkg::*;
#(
  parameter int HOUR_MOD = DEF_HOUR_MOD,
  parameter int MIN_MOD  = DEF_MIN_MOD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_wrap,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic              day_tick,
  output logic [1:0]        set_state
);

  // Last legal value of each field; comparing against these before the
  // increment keeps every register inside its modulus.
  localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MOD - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MOD - 1);

  logic min_ev, mode_ev, inc_ev;

  set_state_t        state_q, state_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              tick_q, tick_d;

  relogio_rise_detect u_min_edge (
    .clk   (clk),
    .reset (reset),
    .level (sec_wrap),
    .rise  (min_ev)
  );

  relogio_rise_detect u_mode_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_mode),
    .rise  (mode_ev)
  );

  relogio_rise_detect u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_inc),
    .rise  (inc_ev)
  );

  // Register the FSM state, both counters and the rollover pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      min_q   <= '0;
      hour_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      tick_q  <= tick_d;
    end
  end

  // Next state and counter updates; the current state decides how events
  // are used, and a mode event always beats an inc event in the set states.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    hour_d  = hour_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (min_ev) begin
          if (min_q == MIN_LAST) begin
            min_d = '0;
            if (hour_q == HOUR_LAST) begin
              hour_d = '0;
              tick_d = 1'b1;
            end else begin
              hour_d = hour_q + 1'b1;
            end
          end else begin
            min_d = min_q + 1'b1;
          end
        end
        if (mode_ev) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (mode_ev) begin
          state_d = ST_SET_MIN;
        end else if (inc_ev) begin
          hour_d = (hour_q == HOUR_LAST) ? '0 : hour_q + 1'b1;
        end
      end
      ST_SET_MIN: begin
        if (mode_ev) begin
          state_d = ST_RUN;
        end else if (inc_ev) begin
          min_d = (min_q == MIN_LAST) ? '0 : min_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign minutes   = min_q;
  assign hours     = hour_q;
  assign day_tick  = tick_q;
  assign set_state = state_q;

endmodule

// File: tb/tb_relogio_min_hora.sv
// Self-checking bench for relogio_min_hora: expected outputs are queued when
// stimulus is driven and compared one clock later, just after the edge.
module tb_relogio_min_hora;
  import relogio_pkg::*;

  logic              clk;
  logic              reset;
  logic              sec_wrap;
  logic              btn_mode;
  logic              btn_inc;
  logic [MIN_W-1:0]  minutes;
  logic [HOUR_W-1:0] hours;
  logic              day_tick;
  logic [1:0]        set_state;

  typedef struct {
    logic [5:0] m;
    logic [4:0] h;
    logic       t;
    logic [1:0] s;
    string      nm;
  } exp_t;

  typedef struct {
    logic       w;
    logic       md;
    logic       ic;
    logic [5:0] m;
    logic [4:0] h;
    logic       t;
    logic [1:0] s;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[14];
  int         total = 0;
  int         bad   = 0;
  logic [5:0] e_min;
  logic [4:0] e_hour;
  set_state_t e_state;

  relogio_min_hora #(.HOUR_MOD(24), .MIN_MOD(60)) dut (
    .clk       (clk),
    .reset     (reset),
    .sec_wrap  (sec_wrap),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .minutes   (minutes),
    .hours     (hours),
    .day_tick  (day_tick),
    .set_state (set_state)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty: no expected entry at time %0t", $time);
      return;
    end
    e = sb.pop_front();
    if (minutes !== e.m || hours !== e.h || day_tick !== e.t || set_state !== e.s) begin
      bad++;
      $display("[TB] FAIL %s: got %0d:%0d tick=%0b state=%0d, want %0d:%0d tick=%0b state=%0d",
               e.nm, hours, minutes, day_tick, set_state, e.h, e.m, e.t, e.s);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic md, input logic ic,
                               input logic [5:0] em, input logic [4:0] eh,
                               input logic et, input logic [1:0] es, input string nm);
    exp_t e;
    sec_wrap = w;
    btn_mode = md;
    btn_inc  = ic;
    e = '{em, eh, et, es, nm};
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic pulse(input logic w, input logic md, input logic ic, input string nm);
    applyStimulus(w, md, ic, e_min, e_hour, 1'b0, e_state, nm);
    applyStimulus(1'b0, 1'b0, 1'b0, e_min, e_hour, 1'b0, e_state, {nm, "_low"});
  endtask

  task automatic bumpHour();
    e_hour = (e_hour == 5'd23) ? 5'd0 : e_hour + 5'd1;
  endtask

  task automatic bumpMin();
    e_min = (e_min == 6'd59) ? 6'd0 : e_min + 6'd1;
  endtask

  task automatic enterAndSet(input logic [4:0] h, input logic [5:0] m);
    e_state = ST_SET_HOUR;
    pulse(1'b0, 1'b1, 1'b0, "preset_mode_hour");
    while (e_hour != h) begin
      bumpHour();
      pulse(1'b0, 1'b0, 1'b1, "preset_inc_hour");
    end
    e_state = ST_SET_MIN;
    pulse(1'b0, 1'b1, 1'b0, "preset_mode_min");
    while (e_min != m) begin
      bumpMin();
      pulse(1'b0, 1'b0, 1'b1, "preset_inc_min");
    end
  endtask

  task automatic goTo(input logic [4:0] h, input logic [5:0] m);
    enterAndSet(h, m);
    e_state = ST_RUN;
    pulse(1'b0, 1'b1, 1'b0, "preset_mode_run");
  endtask

  initial begin
    exp_t er;

    // Vectors start at 00:02 RUN.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 6'd2, 5'd0, 1'b0, 2'd1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 6'd2, 5'd0, 1'b0, 2'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 6'd2, 5'd1, 1'b0, 2'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 6'd2, 5'd1, 1'b0, 2'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 6'd2, 5'd1, 1'b0, 2'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 6'd2, 5'd1, 1'b0, 2'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 6'd2, 5'd1, 1'b0, 2'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 6'd2, 5'd1, 1'b0, 2'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 6'd3, 5'd1, 1'b0, 2'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 6'd3, 5'd1, 1'b0, 2'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 6'd3, 5'd1, 1'b0, 2'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 6'd3, 5'd1, 1'b0, 2'd0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 6'd4, 5'd1, 1'b0, 2'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 6'd4, 5'd1, 1'b0, 2'd0};

    reset    = 1'b0;
    sec_wrap = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;

    $display("[TB] reset with sec_wrap held high");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, ST_RUN, "reset_state");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, ST_RUN, "reset_state_2");
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, ST_RUN, "held_no_count");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, ST_RUN, "held_no_count_2");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, ST_RUN, "wrap_fall");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd1, 5'd0, 1'b0, ST_RUN, "first_minute");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd1, 5'd0, 1'b0, ST_RUN, "first_minute_low");

    $display("[TB] sec_wrap held for 10 cycles");
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd2, 5'd0, 1'b0, ST_RUN, $sformatf("wrap_held_%0d", k));
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd2, 5'd0, 1'b0, ST_RUN, "wrap_held_release");

    $display("[TB] vector table");
    for (int k = 0; k < 14; k++)
      applyStimulus(tbl[k].w, tbl[k].md, tbl[k].ic, tbl[k].m, tbl[k].h, tbl[k].t, tbl[k].s,
                    $sformatf("vec%0d", k));
    e_min   = 6'd4;
    e_hour  = 5'd1;
    e_state = ST_RUN;

    $display("[TB] set path from 05:30");
    goTo(5'd5, 6'd30);
    e_state = ST_SET_HOUR;
    pulse(1'b0, 1'b1, 1'b0, "sp_mode_hour");
    for (int k = 0; k < 20; k++) begin
      bumpHour();
      pulse(1'b0, 1'b0, 1'b1, $sformatf("sp_inc_hour_%0d", k));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd30, 5'd1, 1'b0, ST_SET_HOUR, "sp_hour_wrapped");
    e_state = ST_SET_MIN;
    pulse(1'b0, 1'b1, 1'b0, "sp_mode_min");
    for (int k = 0; k < 31; k++) begin
      bumpMin();
      pulse(1'b0, 1'b0, 1'b1, $sformatf("sp_inc_min_%0d", k));
    end
    pulse(1'b1, 1'b0, 1'b0, "sp_wrap_ignored");
    pulse(1'b1, 1'b0, 1'b0, "sp_wrap_ignored_2");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd1, 5'd1, 1'b0, ST_SET_MIN, "sp_min_wrapped");
    e_state = ST_RUN;
    pulse(1'b0, 1'b1, 1'b0, "sp_mode_run");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd2, 5'd1, 1'b0, ST_RUN, "sp_run_counts");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd2, 5'd1, 1'b0, ST_RUN, "sp_run_counts_low");
    e_min = 6'd2;

    $display("[TB] day rollover from 23:59");
    goTo(5'd23, 6'd59);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 1'b1, ST_RUN, "rollover");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, ST_RUN, "rollover_tick_clear");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, ST_RUN, "rollover_tick_stays_low");
    e_min  = 6'd0;
    e_hour = 5'd0;

    $display("[TB] simultaneous events at 10:15");
    goTo(5'd10, 6'd15);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd16, 5'd10, 1'b0, ST_SET_HOUR, "run_mode_and_min");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd16, 5'd10, 1'b0, ST_SET_HOUR, "run_mode_and_min_low");
    applyStimulus(1'b0, 1'b1, 1'b1, 6'd16, 5'd10, 1'b0, ST_SET_MIN, "sethour_mode_and_inc");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd16, 5'd10, 1'b0, ST_SET_MIN, "sethour_mode_and_inc_low");
    e_min   = 6'd16;
    e_hour  = 5'd10;
    e_state = ST_RUN;
    pulse(1'b0, 1'b1, 1'b0, "back_to_run");

    $display("[TB] asynchronous reset mid SET_MIN at 07:42");
    enterAndSet(5'd7, 6'd42);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd42, 5'd7, 1'b0, ST_SET_MIN, "before_reset");
    #2;
    reset = 1'b0;
    #1;
    er = '{6'd0, 5'd0, 1'b0, ST_RUN, "async_reset"};
    sb.push_back(er);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, ST_RUN, "reset_held");
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 1'b0, ST_RUN, "after_reset_idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd1, 5'd0, 1'b0, ST_RUN, "after_reset_count");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd1, 5'd0, 1'b0, ST_RUN, "after_reset_count_low");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
